ghost_map_scheduler: RTL and testbench
======================================

// Module: ghost_map_scheduler
// PURPOSE
//  Time-shares one synchronous single-port map ROM among the four ghosts.
//  Once per frame it samples all ghost positions and runs 16 fixed lookup slots: 4 ghosts x 4 directions.
//  It returns one registered 4-bit "passable" mask per ghost, consumed by the ghost movement logic.
//  This replaces per-ghost asynchronous MAP reads with a single BRAM-friendly port.
// PARAMETERS
//  MAP_W       32  map width in tiles
//  MAP_H       36  map height in tiles
//  TILE_SHIFT  3   log2 of tile size in pixels (8 px tiles)
//  ADDR_W      11  ROM address width; must cover MAP_W*MAP_H
// PORTS
//  vga_pix_clk  in   1       clock
//  rst          in   1       synchronous, active-high reset
//  frame_stb    in   1       one-cycle strobe per frame; starts a scan
//  x_red/y_red, x_blue/y_blue, x_yellow/y_yellow, x_pink/y_pink
//               in   9 each  ghost pixel positions
//  map_rd       out  1       ROM read enable
//  map_addr     out  ADDR_W  ROM address = tile_x + tile_y*MAP_W
//  map_data     in   4       ROM data, valid 1 cycle after map_rd; bit[3]=passable
//  mask_red, mask_blue, mask_yellow, mask_pink
//               out  4 each  bit d = direction d passable; d: 0=UP 1=RIGHT 2=LEFT 3=DOWN
//  masks_valid  out  1       1-cycle pulse when all four masks update together
//  busy         out  1       high while a scan is in progress
//  overrun      out  1       1-cycle pulse when frame_stb arrives while busy
// BEHAVIOUR
//  Reset values:
//   - state=IDLE; all masks=4'b0000 (all blocked).
//   - map_rd=0, map_addr=0, masks_valid=0, busy=0, overrun=0.
//  FSM IDLE -> SCAN -> FLUSH -> IDLE.
//   - IDLE: on frame_stb, snapshot all 8 positions, set slot=0, go to SCAN.
//   - SCAN: one slot per cycle, slot 0..15; ghost = slot[3:2] (0 red, 1 blue, 2 yellow, 3 pink), dir = slot[1:0].
//     After slot 15, go to FLUSH.
//   - FLUSH: capture the final ROM word, then go to IDLE.
//  Lookup tiles, with tx=x>>3 and ty=y>>3 taken from the snapshot:
//   - UP:    (tx, (y-1)>>3)
//   - DOWN:  (tx, ty+1)
//   - RIGHT: (tx+1, ty)
//   - LEFT:  ((x-1)>>3, ty)
//  Arithmetic is done at 10 bits so that underflow and overflow are detectable.
//  Off-map rule: a slot is blocked when any of the following holds.
//   - y==0 for UP; x==0 for LEFT.
//   - target tile_x>=MAP_W or target tile_y>=MAP_H.
//   - the base tile itself is off-map.
//  A blocked slot:
//   - drives map_rd=0 and map_addr=0;
//   - still consumes its cycle, so scan length is fixed;
//   - records mask bit 0 without using map_data.
//  Each non-blocked slot drives map_rd=1 with its address. map_data[3] is captured on the next edge into a shadow mask bit.
//  Timing: frame_stb sampled on edge E0.
//   - Slot k is driven during the cycle after edge E(k), k=0..15.
//   - The final capture is on E17.
//   - On E17 the shadow masks copy to the mask outputs and masks_valid=1 for that single cycle.
//   - busy is high from the cycle after E0 through the masks_valid cycle inclusive.
//  Output masks hold their value between scans; they never show a partial scan.
//  A frame_stb while busy (SCAN or FLUSH) is ignored and overrun pulses the next cycle.
//  A frame_stb in the same cycle as masks_valid is also ignored, with an overrun pulse.
//  Position inputs may change at any time; only the E0 snapshot is used.
//  rst mid-scan:
//   - abort to IDLE; masks and shadow clear to 0; no masks_valid pulse.
//   - rst has priority over frame_stb in the same cycle.
// TESTING
//  1. Red at (120,112), ROM all 4'b1000.
//     -> slots 0..3 addresses 431, 464, 462, 495.
//     -> mask_red=4'b1111; masks_valid exactly 17 cycles after frame_stb.
//  2. Same position, ROM word 431=4'b0000.
//     -> mask_red=4'b1110; other ghosts unaffected.
//  3. Blue at (0,0) and pink at (248,280).
//     -> blue slots UP and LEFT show map_rd=0, so mask_blue[0]=mask_blue[2]=0.
//     -> pink RIGHT and DOWN are blocked: mask_pink[1]=mask_pink[3]=0.
//  4. frame_stb at E0, then again 5 cycles later.
//     -> overrun pulses once; a single masks_valid pulse at E17; no restart.
//  5. Assert rst at slot 9.
//     -> next cycle: IDLE, all masks 0, busy=0, map_rd=0; no masks_valid.
//  6. Change x_red during the scan.
//     -> the addresses used still match the E0 snapshot.

Source files
------------

// File: rtl/ghost_map_scheduler.sv
// rtl/ghost_map_scheduler.sv - time-shares one synchronous map ROM among four ghosts
// A fixed 16-slot scan per frame yields one registered passable mask per ghost.
module ghost_map_scheduler #(
   parameter int MAP_W      = 32,
   parameter int MAP_H      = 36,
   parameter int TILE_SHIFT = 3,
   parameter int ADDR_W     = 11
) (
   input  logic              vga_pix_clk,
   input  logic              rst,
   input  logic              frame_stb,
   input  logic [8:0]        x_red,
   input  logic [8:0]        y_red,
   input  logic [8:0]        x_blue,
   input  logic [8:0]        y_blue,
   input  logic [8:0]        x_yellow,
   input  logic [8:0]        y_yellow,
   input  logic [8:0]        x_pink,
   input  logic [8:0]        y_pink,
   output logic              map_rd,
   output logic [ADDR_W-1:0] map_addr,
   input  logic [3:0]        map_data,
   output logic [3:0]        mask_red,
   output logic [3:0]        mask_blue,
   output logic [3:0]        mask_yellow,
   output logic [3:0]        mask_pink,
   output logic              masks_valid,
   output logic              busy,
   output logic              overrun
);

   typedef enum logic [1:0] {IDLE, SCAN, FLUSH} state_t;

   localparam logic [9:0]  W10 = 10'(MAP_W);
   localparam logic [9:0]  H10 = 10'(MAP_H);
   localparam logic [19:0] W20 = 20'(MAP_W);

   state_t      state;
   logic [3:0]  cur_slot;
   logic [3:0]  nslot;
   logic [8:0]  live_x [4];
   logic [8:0]  live_y [4];
   logic [8:0]  snap_x [4];
   logic [8:0]  snap_y [4];
   logic [8:0]  sel_x, sel_y;
   logic [9:0]  x10, y10, tx, ty, ttx, tty;
   logic        blk, lk_blocked;
   logic [19:0] addr_full;
   logic [ADDR_W-1:0] lk_addr;
   logic        p1_valid, p1_rd;
   logic [3:0]  p1_slot;
   logic [15:0] shadow, shadow_next;

   assign live_x[0] = x_red;    assign live_y[0] = y_red;
   assign live_x[1] = x_blue;   assign live_y[1] = y_blue;
   assign live_x[2] = x_yellow; assign live_y[2] = y_yellow;
   assign live_x[3] = x_pink;   assign live_y[3] = y_pink;

   // Look up the slot to be driven after the coming edge; slot 0 uses live inputs
   // because the snapshot is being taken on that same edge.
   always_comb begin
      nslot = (state == IDLE) ? 4'd0 : cur_slot + 4'd1;
      if (state == IDLE) begin
         sel_x = live_x[0];
         sel_y = live_y[0];
      end else begin
         sel_x = snap_x[nslot[3:2]];
         sel_y = snap_y[nslot[3:2]];
      end
      x10 = {1'b0, sel_x};
      y10 = {1'b0, sel_y};
      tx  = x10 >> TILE_SHIFT;
      ty  = y10 >> TILE_SHIFT;
      ttx = tx;
      tty = ty;
      blk = 1'b0;
      case (nslot[1:0])
         2'd0: begin
            blk = (y10 == 10'd0);
            tty = (y10 - 10'd1) >> TILE_SHIFT;
         end
         2'd1: ttx = tx + 10'd1;
         2'd2: begin
            blk = (x10 == 10'd0);
            ttx = (x10 - 10'd1) >> TILE_SHIFT;
         end
         default: tty = ty + 10'd1;
      endcase
      lk_blocked = blk || (tx >= W10) || (ty >= H10) || (ttx >= W10) || (tty >= H10);
      addr_full  = {10'd0, ttx} + {10'd0, tty} * W20;
      lk_addr    = addr_full[ADDR_W-1:0];
   end

   // The ROM word for a slot arrives two edges after the slot was registered.
   always_comb begin
      shadow_next = shadow;
      if (p1_valid)
         shadow_next[p1_slot] = p1_rd & map_data[3];
   end

   always_ff @(posedge vga_pix_clk) begin
      if (rst) begin
         state       <= IDLE;
         cur_slot    <= 4'd0;
         map_rd      <= 1'b0;
         map_addr    <= '0;
         p1_valid    <= 1'b0;
         p1_rd       <= 1'b0;
         p1_slot     <= 4'd0;
         shadow      <= 16'd0;
         mask_red    <= 4'd0;
         mask_blue   <= 4'd0;
         mask_yellow <= 4'd0;
         mask_pink   <= 4'd0;
         masks_valid <= 1'b0;
         busy        <= 1'b0;
         overrun     <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            snap_x[i] <= 9'd0;
            snap_y[i] <= 9'd0;
         end
      end else begin
         masks_valid <= 1'b0;
         overrun     <= frame_stb && busy;
         p1_valid    <= (state == SCAN);
         p1_slot     <= cur_slot;
         p1_rd       <= map_rd;
         shadow      <= shadow_next;
         case (state)
            IDLE: begin
               if (frame_stb && !busy) begin
                  for (int i = 0; i < 4; i++) begin
                     snap_x[i] <= live_x[i];
                     snap_y[i] <= live_y[i];
                  end
                  cur_slot <= 4'd0;
                  map_rd   <= !lk_blocked;
                  map_addr <= lk_blocked ? '0 : lk_addr;
                  busy     <= 1'b1;
                  state    <= SCAN;
               end else if (masks_valid) begin
                  busy <= 1'b0;
               end
            end
            SCAN: begin
               if (cur_slot == 4'd15) begin
                  map_rd   <= 1'b0;
                  map_addr <= '0;
                  state    <= FLUSH;
               end else begin
                  cur_slot <= nslot;
                  map_rd   <= !lk_blocked;
                  map_addr <= lk_blocked ? '0 : lk_addr;
               end
            end
            FLUSH: begin
               mask_red    <= shadow_next[3:0];
               mask_blue   <= shadow_next[7:4];
               mask_yellow <= shadow_next[11:8];
               mask_pink   <= shadow_next[15:12];
               masks_valid <= 1'b1;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ghost_map_scheduler.sv
// tb/tb_ghost_map_scheduler.sv - randomized and directed checks against a tile-arithmetic model
module tb_ghost_map_scheduler;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, frame_stb;
   logic [8:0]  gx [4];
   logic [8:0]  gy [4];
   logic        map_rd;
   logic [10:0] map_addr;
   logic [3:0]  map_data;
   logic [3:0]  mask_red, mask_blue, mask_yellow, mask_pink;
   logic        masks_valid, busy, overrun;

   logic [3:0]  rom [2048];
   logic [3:0]  rom_q = 4'd0;
   always @(posedge clk) if (map_rd) rom_q <= rom[map_addr];
   assign map_data = rom_q;

   ghost_map_scheduler dut (
      .vga_pix_clk(clk), .rst(rst), .frame_stb(frame_stb),
      .x_red(gx[0]), .y_red(gy[0]), .x_blue(gx[1]), .y_blue(gy[1]),
      .x_yellow(gx[2]), .y_yellow(gy[2]), .x_pink(gx[3]), .y_pink(gy[3]),
      .map_rd(map_rd), .map_addr(map_addr), .map_data(map_data),
      .mask_red(mask_red), .mask_blue(mask_blue), .mask_yellow(mask_yellow), .mask_pink(mask_pink),
      .masks_valid(masks_valid), .busy(busy), .overrun(overrun)
   );

   int total = 0;
   int passed = 0;
   bit exp_rd [16];
   int exp_addr [16];
   logic [3:0] model_mask [4];
   logic [3:0] pend_mask [4];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic logic [3:0] dut_mask(input int g);
      case (g)
         0: return mask_red;
         1: return mask_blue;
         2: return mask_yellow;
         default: return mask_pink;
      endcase
   endfunction

   // Tile rules with plain integer arithmetic: d 0=UP 1=RIGHT 2=LEFT 3=DOWN.
   function automatic void lookup(input int x, input int y, input int d, output bit rd, output int addr);
      int tx, ty, nx, ny;
      tx = x / 8; ty = y / 8; nx = tx; ny = ty; rd = 1'b1;
      case (d)
         0: if (y == 0) rd = 1'b0; else ny = (y - 1) / 8;
         1: nx = tx + 1;
         2: if (x == 0) rd = 1'b0; else nx = (x - 1) / 8;
         default: ny = ty + 1;
      endcase
      if (tx >= 32 || ty >= 36 || nx >= 32 || ny >= 36) rd = 1'b0;
      addr = rd ? nx + ny * 32 : 0;
   endfunction

   task automatic predict();
      bit rd; int a;
      for (int s = 0; s < 16; s++) begin
         lookup(int'(gx[s/4]), int'(gy[s/4]), s % 4, rd, a);
         exp_rd[s] = rd;
         exp_addr[s] = a;
         pend_mask[s/4][s%4] = rd && rom[a][3];
      end
   endtask

   task automatic check_masks(input string tag);
      for (int g = 0; g < 4; g++)
         chk($sformatf("%s_mask%0d", tag, g), 32'(dut_mask(g)), 32'(model_mask[g]));
   endtask

   task automatic run_scan(input int extra, input int mutate, input int rst_at);
      predict();
      frame_stb = 1'b1;
      step();
      frame_stb = 1'b0;
      for (int i = 0; i < 19; i++) begin
         if (i == rst_at) begin
            rst = 1'b1;
            step();
            rst = 1'b0;
            for (int g = 0; g < 4; g++) model_mask[g] = 4'd0;
            chk("rst_busy", 32'(busy), 0);
            chk("rst_rd", 32'(map_rd), 0);
            chk("rst_mv", 32'(masks_valid), 0);
            check_masks("rst");
            for (int j = 0; j < 12; j++) begin
               step();
               chk("rst_no_mv", 32'(masks_valid), 0);
            end
            return;
         end
         if (i < 16) begin
            chk($sformatf("rd_s%0d", i), 32'(map_rd), 32'(exp_rd[i]));
            chk($sformatf("addr_s%0d", i), 32'(map_addr), 32'(exp_addr[i]));
         end else begin
            chk($sformatf("rd_idle%0d", i), 32'(map_rd), 0);
         end
         chk($sformatf("busy_%0d", i), 32'(busy), 32'(i <= 17));
         chk($sformatf("mv_%0d", i), 32'(masks_valid), 32'(i == 17));
         chk($sformatf("ovr_%0d", i), 32'(overrun), 32'(extra >= 0 && i == extra + 1));
         if (i == 17)
            for (int g = 0; g < 4; g++) model_mask[g] = pend_mask[g];
         check_masks($sformatf("c%0d", i));
         if (i == extra) frame_stb = 1'b1;
         if (i == mutate) begin
            gx[0] = 9'($urandom_range(0, 511));
            gy[0] = 9'($urandom_range(0, 511));
         end
         step();
         frame_stb = 1'b0;
      end
   endtask

   initial begin
      rst = 1'b1;
      frame_stb = 1'b0;
      for (int g = 0; g < 4; g++) begin
         gx[g] = 9'd0; gy[g] = 9'd0; model_mask[g] = 4'd0;
      end
      for (int a = 0; a < 2048; a++) rom[a] = 4'b1000;
      step();
      step();
      rst = 1'b0;
      chk("reset_rd", 32'(map_rd), 0);
      chk("reset_addr", 32'(map_addr), 0);
      chk("reset_mv", 32'(masks_valid), 0);
      chk("reset_busy", 32'(busy), 0);
      chk("reset_ovr", 32'(overrun), 0);
      check_masks("reset");

      // Red at (120,112), open ROM.
      gx[0] = 9'd120; gy[0] = 9'd112;
      gx[1] = 9'd40;  gy[1] = 9'd40;
      gx[2] = 9'd80;  gy[2] = 9'd200;
      gx[3] = 9'd16;  gy[3] = 9'd16;
      run_scan(-1, -1, -1);
      chk("t1_mask_red", 32'(mask_red), 32'h0f);
      step();

      // Word 431 blocked.
      rom[431] = 4'b0000;
      run_scan(-1, -1, -1);
      chk("t2_mask_red", 32'(mask_red), 32'h0e);
      rom[431] = 4'b1000;
      step();

      // Map-edge ghosts.
      gx[1] = 9'd0;   gy[1] = 9'd0;
      gx[3] = 9'd248; gy[3] = 9'd280;
      run_scan(-1, -1, -1);
      chk("t3_mask_blue", 32'(mask_blue), 32'h0a);
      chk("t3_mask_pink", 32'(mask_pink), 32'h05);

      // Second strobe 5 cycles in, then a strobe during the masks_valid cycle.
      run_scan(5, -1, -1);
      run_scan(17, -1, -1);

      // Reset mid-scan at slot 9.
      run_scan(-1, -1, 9);

      // Reset wins over a simultaneous frame strobe.
      rst = 1'b1; frame_stb = 1'b1;
      step();
      rst = 1'b0; frame_stb = 1'b0;
      chk("rst_prio_busy", 32'(busy), 0);
      chk("rst_prio_rd", 32'(map_rd), 0);
      step();
      chk("rst_prio_busy2", 32'(busy), 0);

      // Red position changes mid-scan.
      run_scan(-1, 2, -1);
      run_scan(-1, 8, -1);

      // Random positions and ROM contents.
      for (int r = 0; r < 8; r++) begin
         for (int a = 0; a < 2048; a++) rom[a] = 4'($urandom);
         for (int g = 0; g < 4; g++) begin
            gx[g] = 9'($urandom_range(0, 300));
            gy[g] = 9'($urandom_range(0, 300));
            if ($urandom_range(0, 5) == 0) gx[g] = 9'd0;
            if ($urandom_range(0, 5) == 0) gy[g] = 9'd0;
         end
         run_scan(($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 17)) : -1,
                  int'($urandom_range(0, 18)), -1);
         repeat ($urandom_range(0, 3)) step();
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
